// File: rtl/dwrr_pkg.sv
// Shared sizing for the DWRR arbiter and its requestor-side queues, so both
// ends derive flow-index and occupancy widths the same way.
package dwrr_pkg;

    localparam int NUM_REQS_DEF = 4;

    // A single flow still needs a 1-bit index field.
    function automatic int cnt_width(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 1;
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Single-clock packet FIFO with occupancy count; push is ignored when full,
// pop must only be issued when non-empty.
module pkt_fifo
    import dwrr_pkg::*;
#(
    parameter int DWID   = 8,
    parameter int DEPTH  = 4,
    parameter int AWID   = $clog2(DEPTH),
    parameter int OCCWID = occ_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DWID-1:0]   push_data,
    input  logic              pop,
    output logic [DWID-1:0]   head,
    output logic [OCCWID-1:0] occ,
    output logic              full,
    output logic              empty
);

    logic [DWID-1:0] mem [DEPTH];
    logic [AWID-1:0] wptr;
    logic [AWID-1:0] rptr;
    logic            push_acc;

    assign full     = (occ == OCCWID'(DEPTH));
    assign empty    = (occ == '0);
    assign push_acc = push & ~full;
    assign head     = mem[rptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push_acc) begin
                wptr <= wptr + AWID'(1);
            end
            if (pop) begin
                rptr <= rptr + AWID'(1);
            end
            case ({push_acc, pop})
                2'b10:   occ <= occ + OCCWID'(1);
                2'b01:   occ <= occ - OCCWID'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/dwrr_req_queues.sv
// Requestor side of the DWRR req/gnt handshake: per-flow FIFOs raise reqs,
// a legal one-hot gnt pops one packet onto a registered output stream.
module dwrr_req_queues
    import dwrr_pkg::*;
#(
    parameter int NUM_REQS = NUM_REQS_DEF,
    parameter int DWID     = 8,
    parameter int DEPTH    = 4,
    parameter int AWID     = $clog2(DEPTH),
    parameter int OCCWID   = occ_width(DEPTH),
    parameter int CNTWID   = cnt_width(NUM_REQS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQS-1:0]        push_vld,
    input  logic [NUM_REQS*DWID-1:0]   push_data,
    output logic [NUM_REQS-1:0]        push_rdy,
    output logic [NUM_REQS-1:0]        reqs,
    input  logic [NUM_REQS-1:0]        gnt,
    output logic                       out_vld,
    output logic [DWID-1:0]            out_data,
    output logic [CNTWID-1:0]          out_id,
    output logic [NUM_REQS*OCCWID-1:0] occ,
    output logic                       gnt_err
);

    logic [DWID-1:0]     heads [NUM_REQS];
    logic [NUM_REQS-1:0] full;
    logic [NUM_REQS-1:0] empty;
    logic [NUM_REQS-1:0] pop;
    logic                gnt_any;
    logic                gnt_onehot;
    logic                gnt_legal;
    logic                gnt_bad;
    logic [DWID-1:0]     sel_data;
    logic [CNTWID-1:0]   sel_id;
    logic                vld_p1;
    logic [DWID-1:0]     data_p1;
    logic [CNTWID-1:0]   id_p1;
    logic                err_p1;

    // reqs and push_rdy come only from registered FIFO state, since the
    // arbiter closes a combinational loop from reqs back to gnt.
    assign reqs     = ~empty;
    assign push_rdy = ~full;

    assign gnt_any    = |gnt;
    assign gnt_onehot = gnt_any && ((gnt & (gnt - NUM_REQS'(1))) == '0);
    assign gnt_legal  = gnt_onehot && ((gnt & ~reqs) == '0);
    assign gnt_bad    = gnt_any && !gnt_legal;
    assign pop        = gnt_legal ? gnt : '0;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_q
        pkt_fifo #(
            .DWID   (DWID),
            .DEPTH  (DEPTH),
            .AWID   (AWID),
            .OCCWID (OCCWID)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_vld[i]),
            .push_data (push_data[i*DWID +: DWID]),
            .pop       (pop[i]),
            .head      (heads[i]),
            .occ       (occ[i*OCCWID +: OCCWID]),
            .full      (full[i]),
            .empty     (empty[i])
        );
    end

    always_comb begin
        sel_data = '0;
        sel_id   = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (gnt[i]) begin
                sel_data = heads[i];
                sel_id   = CNTWID'(i);
            end
        end
    end

    // Stage p1: popped packet register and sticky protocol error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            id_p1   <= '0;
            err_p1  <= 1'b0;
        end else begin
            vld_p1 <= gnt_legal;
            err_p1 <= err_p1 | gnt_bad;
            if (gnt_legal) begin
                data_p1 <= sel_data;
                id_p1   <= sel_id;
            end
        end
    end

    assign out_vld  = vld_p1;
    assign out_data = data_p1;
    assign out_id   = id_p1;
    assign gnt_err  = err_p1;

endmodule

// File: tb/tb_dwrr_req_queues.sv
// Directed bench for dwrr_req_queues: push/pop ordering, full and empty
// edges, illegal grants and asynchronous reset mid-stream.
module tb_dwrr_req_queues;

    localparam int NUM_REQS = 4;
    localparam int DWID     = 8;
    localparam int DEPTH    = 4;
    localparam int OCCWID   = 3;
    localparam int CNTWID   = 2;

    logic                       clk;
    logic                       rst;
    logic [NUM_REQS-1:0]        push_vld;
    logic [NUM_REQS*DWID-1:0]   push_data;
    logic [NUM_REQS-1:0]        push_rdy;
    logic [NUM_REQS-1:0]        reqs;
    logic [NUM_REQS-1:0]        gnt;
    logic                       out_vld;
    logic [DWID-1:0]            out_data;
    logic [CNTWID-1:0]          out_id;
    logic [NUM_REQS*OCCWID-1:0] occ;
    logic                       gnt_err;

    int checks   = 0;
    int failures = 0;

    dwrr_req_queues #(
        .NUM_REQS (NUM_REQS),
        .DWID     (DWID),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push_vld  (push_vld),
        .push_data (push_data),
        .push_rdy  (push_rdy),
        .reqs      (reqs),
        .gnt       (gnt),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .out_id    (out_id),
        .occ       (occ),
        .gnt_err   (gnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] occ_of(input int q);
        return 32'(occ[q*OCCWID +: OCCWID]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int q, input logic [DWID-1:0] v);
        push_data[q*DWID +: DWID] = v;
    endtask

    logic [DWID-1:0] drain0 [4] = '{8'h11, 8'h12, 8'h13, 8'h15};

    initial begin
        rst       = 1'b1;
        push_vld  = '0;
        push_data = '0;
        gnt       = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_gnt_err", 32'(gnt_err), 32'd0);
        check("rst_reqs", 32'(reqs), 32'h0);
        check("rst_push_rdy", 32'(push_rdy), 32'hF);
        check("rst_occ", 32'(occ), 32'h0);

        // Two pushes to flow 2, then two consecutive grants
        push_vld = 4'b0100; set_data(2, 8'hA1);
        tick();
        check("f2_reqs_after_first", 32'(reqs), 32'h4);
        set_data(2, 8'hA2);
        tick();
        push_vld = '0;
        check("f2_occ2", occ_of(2), 32'd2);
        gnt = 4'b0100;
        tick();
        check("f2_pop1_vld", 32'(out_vld), 32'd1);
        check("f2_pop1_data", 32'(out_data), 32'hA1);
        check("f2_pop1_id", 32'(out_id), 32'd2);
        check("f2_reqs_mid", 32'(reqs), 32'h4);
        tick();
        gnt = '0;
        check("f2_pop2_vld", 32'(out_vld), 32'd1);
        check("f2_pop2_data", 32'(out_data), 32'hA2);
        check("f2_reqs_fell", 32'(reqs), 32'h0);
        check("f2_gnt_err", 32'(gnt_err), 32'd0);
        tick();
        check("idle_vld", 32'(out_vld), 32'd0);
        check("idle_data_hold", 32'(out_data), 32'hA2);
        check("idle_id_hold", 32'(out_id), 32'd2);

        // Fill flow 0, then push against full while popping
        push_vld = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            set_data(0, 8'(8'h10 + k));
            tick();
        end
        check("full_push_rdy", 32'(push_rdy), 32'hE);
        check("full_occ0", occ_of(0), 32'd4);
        set_data(0, 8'h14);
        gnt = 4'b0001;
        tick();
        check("full_pop_data", 32'(out_data), 32'h10);
        check("full_pop_id", 32'(out_id), 32'd0);
        check("full_drop_occ0", occ_of(0), 32'd3);
        gnt = '0;
        set_data(0, 8'h15);
        tick();
        push_vld = '0;
        check("full_refill_occ0", occ_of(0), 32'd4);
        gnt = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("drain0_data", 32'(out_data), 32'(drain0[k]));
        end
        gnt = '0;
        check("drain0_occ0", occ_of(0), 32'd0);

        // Simultaneous push and pop on flow 1
        push_vld = 4'b0010; set_data(1, 8'h20);
        tick();
        check("pp_occ1_pre", occ_of(1), 32'd1);
        set_data(1, 8'h21);
        gnt = 4'b0010;
        tick();
        push_vld = '0;
        check("pp_occ1", occ_of(1), 32'd1);
        check("pp_old_head", 32'(out_data), 32'h20);
        tick();
        gnt = '0;
        check("pp_new_head", 32'(out_data), 32'h21);
        check("pp_occ1_post", occ_of(1), 32'd0);

        // Multi-hot grant
        push_vld = 4'b0011; set_data(0, 8'h30); set_data(1, 8'h31);
        tick();
        push_vld = '0;
        gnt = 4'b0011;
        tick();
        gnt = '0;
        check("mh_vld", 32'(out_vld), 32'd0);
        check("mh_err", 32'(gnt_err), 32'd1);
        check("mh_occ0", occ_of(0), 32'd1);
        check("mh_occ1", occ_of(1), 32'd1);
        tick();
        check("mh_err_sticky", 32'(gnt_err), 32'd1);

        // Asynchronous reset with queues populated and a pop in flight
        push_vld = 4'b1000; set_data(3, 8'h40);
        tick();
        set_data(3, 8'h41);
        gnt = 4'b0001;
        tick();
        push_vld = '0;
        gnt = '0;
        check("ar_inflight_vld", 32'(out_vld), 32'd1);
        check("ar_inflight_data", 32'(out_data), 32'h30);
        #2 rst = 1'b1;
        #1;
        check("ar_vld", 32'(out_vld), 32'd0);
        check("ar_data", 32'(out_data), 32'd0);
        check("ar_occ", 32'(occ), 32'd0);
        check("ar_reqs", 32'(reqs), 32'd0);
        check("ar_rdy", 32'(push_rdy), 32'hF);
        check("ar_err", 32'(gnt_err), 32'd0);
        tick();
        rst = 1'b0;

        // Grant to an empty queue after reset
        gnt = 4'b0100;
        tick();
        gnt = '0;
        check("eg_vld", 32'(out_vld), 32'd0);
        check("eg_err", 32'(gnt_err), 32'd1);

        // Push plus grant to the same empty queue: error, push still lands
        push_vld = 4'b0100; set_data(2, 8'h60);
        gnt = 4'b0100;
        tick();
        push_vld = '0;
        gnt = '0;
        check("pe_vld", 32'(out_vld), 32'd0);
        check("pe_occ2", occ_of(2), 32'd1);

        // Post-reset order on flow 3 from pointer 0
        push_vld = 4'b1000; set_data(3, 8'h50);
        tick();
        set_data(3, 8'h51);
        tick();
        push_vld = '0;
        gnt = 4'b1000;
        tick();
        check("pr_data0", 32'(out_data), 32'h50);
        check("pr_id0", 32'(out_id), 32'd3);
        tick();
        gnt = '0;
        check("pr_data1", 32'(out_data), 32'h51);
        check("pr_reqs", 32'(reqs), 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dwrr_req_queues.md
Name: dwrr_req_queues

Overview:
- Requestor side of the DWRR req/gnt interface: a bank of NUM_REQS per-flow packet FIFOs.
- Drives the arbiter's reqs vector from queue non-empty status and consumes its one-hot gnt vector.
- Each granted packet is popped and presented on a single registered output stream, tagged with its flow index.
- Sits between flow ingress logic and the DWRR arbiter; the output stream feeds the shared egress link.

Parameters:
- NUM_REQS, 4, number of flows/queues; must equal the arbiter's NUM_REQS.
- DWID, 8, packet (one entry) data width.
- DEPTH, 4, entries per queue; power of 2, at least 2.
- AWID, $clog2(DEPTH), FIFO pointer width.
- OCCWID, $clog2(DEPTH+1), occupancy counter width.
- CNTWID, $clog2(NUM_REQS), flow index width.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- push_vld  input  NUM_REQS  per-flow write request.
- push_data  input  NUM_REQS*DWID  per-flow write data; flow i occupies bits [(i+1)*DWID-1:i*DWID].
- push_rdy  output  NUM_REQS  per-flow space available.
- reqs  output  NUM_REQS  to arbiter; bit i high when queue i is non-empty.
- gnt  input  NUM_REQS  from arbiter; at most one bit is expected high per cycle.
- out_vld  output  1  popped packet valid.
- out_data  output  DWID  popped packet data.
- out_id  output  CNTWID  flow index of the popped packet.
- occ  output  NUM_REQS*OCCWID  per-queue occupancy, packed like push_data.
- gnt_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (asynchronous assert, state cleared immediately):
  - All occupancy counts, read pointers and write pointers go to 0.
  - out_vld=0, out_data=0, out_id=0, gnt_err=0.
  - reqs=0 and push_rdy=all-ones follow from the cleared state.
  - Reset mid-operation discards all queued packets and any in-flight output; there is no drain.
- Path rules:
  - reqs[i] = (occ[i] != 0) and push_rdy[i] = (occ[i] != DEPTH), both decoded from registered state only.
  - There is no combinational path from gnt or push_vld to reqs or push_rdy. This is mandatory because the arbiter's gnt is combinational from reqs.
- Push: when push_vld[i] & push_rdy[i], the entry is written at wptr[i]; wptr[i] wraps modulo DEPTH.
- Pop:
  - A legal gnt (exactly one bit i set, with reqs[i]=1) pops the head of queue i; rptr[i] wraps modulo DEPTH.
  - Latency is 1 cycle: on the next edge out_vld=1, out_data=head entry, out_id=i.
  - With no legal gnt, out_vld=0 on the next edge; out_data and out_id hold their previous values.
- Occupancy update per queue:
  - push only: +1. Pop only: -1. Push and pop together: unchanged, both pointers advance.
- Full: push_rdy=0, so push_vld is ignored. This holds even if the same queue is popped that cycle (no full bypass).
- Empty:
  - reqs=0; a push becomes visible on reqs the next cycle (empty-to-req latency 1).
  - A push and a gnt to the same empty queue in the same cycle is a gnt to an empty queue (error case below); the push still completes.
- Error handling:
  - Multi-hot gnt, or gnt[i] with reqs[i]=0: no pop on any queue, out_vld=0 next cycle, gnt_err set.
  - gnt_err stays high until reset. Pushes are unaffected.
- The arbiter may hold gnt on the same queue on consecutive cycles; each cycle pops one entry. After the last entry is popped, reqs[i] falls on the following cycle.
- Width rules: occ never exceeds DEPTH; pointers are unsigned and wrap naturally because DEPTH is a power of 2.

Decomposition:
- Shared package dwrr_pkg holds the NUM_REQS default and the CNTWID/OCCWID derivation functions, so the arbiter and queues agree on widths.
- One sub-module, pkt_fifo (parameters DWID, DEPTH): a single-clock FIFO with push/pop, full/empty and occ, instantiated NUM_REQS times in a generate loop.
- Top level adds gnt legality checking (onehot check, gnt & reqs), the output mux and register, and the sticky error flag.

Test Plan:
- Reset, then push 0xA1,0xA2 to flow 2 on consecutive cycles -> reqs=4'b0100 from the cycle after the first push; occ[2]=2.
- gnt=4'b0100 for two cycles -> out_vld high for two cycles with out_data 0xA1 then 0xA2, out_id=2; reqs[2] falls after the second pop; gnt_err=0.
- Fill flow 0 with 4 entries -> push_rdy[0]=0. A fifth push_vld together with gnt[0] -> the fifth push is dropped and occ[0]=3; the next cycle a push is accepted.
- With occ[1]=1, push and gnt[1] in the same cycle -> occ[1] stays 1, out_data is the old head, and the new entry is the next head.
- gnt=4'b0011 with both queues non-empty -> no pop, out_vld=0, gnt_err=1 and stays 1. gnt to an empty queue after reset gives the same result.
- Assert rst asynchronously mid-stream with queues half full -> outputs clear immediately, occ=0, reqs=0, and later pushes are read back in order starting from pointer 0.
